// File: rtl/irq_pkg.sv
// Shared types and default sizing for the interrupt pending latch.
// The IRQ_OVERFLOW_EN macro (see irq_pending_latch) adds per-line overflow flags.
package irq_pkg;

    typedef enum logic {
        IRQ_IDLE  = 1'b0,
        IRQ_OFFER = 1'b1
    } irq_state_t;

    localparam int IRQ_N = 8;
    localparam int IRQ_M = $clog2(IRQ_N);

endpackage

// File: rtl/irq_edge_detect.sv
// Rising-edge detector for N synchronous request lines.
// A line already high when reset is released is treated as a level, not an edge.
module irq_edge_detect
    import irq_pkg::*;
#(
    parameter int N = IRQ_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] irq_i,
    output logic [N-1:0] rise
);

    logic [N-1:0] irq_q;
    logic         armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= '0;
            armed <= 1'b0;
        end else begin
            irq_q <= irq_i;
            armed <= 1'b1;
        end
    end

    // The first edge after reset only loads irq_q, so held-high lines do not fire.
    assign rise = armed ? (irq_i & ~irq_q) : '0;

endmodule

// File: rtl/irq_pending_latch.sv
// Sticky pending latch feeding an external priority encoder, with a valid/ready offer.
// Define IRQ_OVERFLOW_EN to add the sticky per-line overflow output ovf_o.
module irq_pending_latch
    import irq_pkg::*;
#(
    parameter int N = IRQ_N,
    parameter int M = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] irq_i,
    input  logic [N-1:0] mask_i,
    output logic [N-1:0] pend_o,
    input  logic [M-1:0] enc_idx_i,
    output logic         req_valid,
    output logic [M-1:0] req_idx,
    input  logic         req_ready
`ifdef IRQ_OVERFLOW_EN
    ,
    output logic [N-1:0] ovf_o
`endif
);

    irq_state_t   state;
    irq_state_t   state_nxt;
    logic [M-1:0] idx_nxt;
    logic [N-1:0] rise;
    logic [N-1:0] clr;
    logic [N-1:0] pending;
    logic [N-1:0] pend_keep;
    logic [N-1:0] pend_nxt;

    irq_edge_detect #(.N(N)) u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .irq_i (irq_i),
        .rise  (rise)
    );

    // Handshake: a transfer happens on a rising edge where req_valid & req_ready.
    // Once raised, req_valid and req_idx hold unchanged until that transfer (no retraction).
    always_comb begin
        state_nxt = state;
        idx_nxt   = req_idx;
        clr       = '0;
        case (state)
            IRQ_IDLE: begin
                if (|pend_o) begin
                    idx_nxt   = enc_idx_i;
                    state_nxt = IRQ_OFFER;
                end
            end
            IRQ_OFFER: begin
                if (req_ready) begin
                    clr       = N'(1) << req_idx;
                    state_nxt = IRQ_IDLE;
                end
            end
            default: state_nxt = IRQ_IDLE;
        endcase
    end

    // pend_o excludes same-cycle rises so a new edge reaches the encoder one cycle
    // after it is latched, while a served bit leaves pend_o in time for the IDLE bubble.
    always_comb begin
        pend_keep = pending & ~clr;
        pend_nxt  = pend_keep | rise;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IRQ_IDLE;
            req_idx <= '0;
            pending <= '0;
            pend_o  <= '0;
        end else begin
            state   <= state_nxt;
            req_idx <= idx_nxt;
            pending <= pend_nxt;
            pend_o  <= pend_keep & ~mask_i;
        end
    end

    assign req_valid = (state == IRQ_OFFER);

`ifdef IRQ_OVERFLOW_EN
    logic [N-1:0] ovf_q;

    // A re-edge on a line that is pending and not being served this cycle overflows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= (ovf_q & ~clr) | (rise & pending & ~clr);
        end
    end

    assign ovf_o = ovf_q;
`endif

endmodule

// File: tb/tb_irq_pending_latch.sv
// Directed bench for irq_pending_latch (N=8) with a behavioural highest-index encoder.
// Overflow checks are compiled in when IRQ_OVERFLOW_EN is defined.
module tb_irq_pending_latch;

    localparam int N = 8;
    localparam int M = 3;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] irq_i;
    logic [N-1:0] mask_i;
    logic [N-1:0] pend_o;
    logic [M-1:0] enc_idx_i;
    logic         req_valid;
    logic [M-1:0] req_idx;
    logic         req_ready;
`ifdef IRQ_OVERFLOW_EN
    logic [N-1:0] ovf_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    irq_pending_latch #(.N(N), .M(M)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_i     (irq_i),
        .mask_i    (mask_i),
        .pend_o    (pend_o),
        .enc_idx_i (enc_idx_i),
        .req_valid (req_valid),
        .req_idx   (req_idx),
        .req_ready (req_ready)
`ifdef IRQ_OVERFLOW_EN
        ,
        .ovf_o     (ovf_o)
`endif
    );

    // Clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural encoder: highest set bit wins, 0 when empty
    always_comb begin
        enc_idx_i = '0;
        for (int i = 0; i < N; i++) begin
            if (pend_o[i]) enc_idx_i = M'(i);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_offer(input string tag, input logic v, input logic [M-1:0] idx);
        check({tag, "_valid"}, 32'(req_valid), 32'(v));
        if (v) check({tag, "_idx"}, 32'(req_idx), 32'(idx));
    endtask

    initial begin
        rst_n     = 1'b0;
        irq_i     = 8'hFF;
        mask_i    = 8'h00;
        req_ready = 1'b0;

        // 1 Reset with all lines high
        tick();
        tick();
        check("rst_pend", 32'(pend_o), 32'h00);
        check("rst_valid", 32'(req_valid), 32'h0);
        check("rst_idx", 32'(req_idx), 32'h0);
`ifdef IRQ_OVERFLOW_EN
        check("rst_ovf", 32'(ovf_o), 32'h00);
`endif
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        check("rst_held_pend", 32'(pend_o), 32'h00);
        check("rst_held_valid", 32'(req_valid), 32'h0);
        irq_i = 8'h00;
        tick();
        tick();
        check("fall_pend", 32'(pend_o), 32'h00);

        // 2 Single request on line 5
        irq_i[5]  = 1'b1;
        req_ready = 1'b1;
        tick();                                   // edge k
        irq_i = 8'h00;
        check("single_k_pend", 32'(pend_o), 32'h00);
        check_offer("single_k", 1'b0, 3'd0);
        tick();                                   // k+1
        check("single_k1_pend", 32'(pend_o), 32'h20);
        check_offer("single_k1", 1'b0, 3'd0);
        tick();                                   // k+2
        check_offer("single_k2", 1'b1, 3'd5);
        tick();                                   // handshake
        check_offer("single_hs", 1'b0, 3'd0);
        tick();
        tick();
        check("single_clr_pend", 32'(pend_o), 32'h00);
        check_offer("single_idle", 1'b0, 3'd0);

        // 3 Priority order across lines 1,3,6
        irq_i = 8'h4A;
        tick();
        irq_i = 8'h00;
        tick();
        check("prio_pend0", 32'(pend_o), 32'h4A);
        tick();
        check_offer("prio_g6", 1'b1, 3'd6);
        tick();
        check_offer("prio_b0", 1'b0, 3'd0);
        check("prio_pend1", 32'(pend_o), 32'h0A);
        tick();
        check_offer("prio_g3", 1'b1, 3'd3);
        tick();
        check("prio_pend2", 32'(pend_o), 32'h02);
        tick();
        check_offer("prio_g1", 1'b1, 3'd1);
        tick();
        check("prio_pend3", 32'(pend_o), 32'h00);
        tick();
        check_offer("prio_idle", 1'b0, 3'd0);

        // 4 Backpressure with mask raised mid-offer
        req_ready = 1'b0;
        irq_i[2]  = 1'b1;
        tick();
        irq_i = 8'h00;
        tick();
        tick();
        check_offer("bp_offer", 1'b1, 3'd2);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) mask_i[2] = 1'b1;
            tick();
            check_offer("bp_hold", 1'b1, 3'd2);
        end
        check("bp_masked_pend", 32'(pend_o), 32'h00);
        req_ready = 1'b1;
        tick();
        check_offer("bp_accept", 1'b0, 3'd0);
        req_ready = 1'b0;
        mask_i    = 8'h00;
        tick();
        tick();
        check("bp_cleared_pend", 32'(pend_o), 32'h00);
        check_offer("bp_idle", 1'b0, 3'd0);

        // Masked line stays latched and appears once unmasked
        mask_i[7] = 1'b1;
        irq_i[7]  = 1'b1;
        tick();
        irq_i = 8'h00;
        tick();
        tick();
        tick();
        check("mask_hidden_pend", 32'(pend_o), 32'h00);
        check_offer("mask_hidden", 1'b0, 3'd0);
        mask_i = 8'h00;
        tick();
        check("mask_shown_pend", 32'(pend_o), 32'h80);
        tick();
        check_offer("mask_offer", 1'b1, 3'd7);
        req_ready = 1'b1;
        tick();
        check_offer("mask_accept", 1'b0, 3'd0);
        req_ready = 1'b0;
        tick();

        // 5 Re-edge of line 4 in its accept cycle: set beats clear
        irq_i[4] = 1'b1;
        tick();
        irq_i = 8'h00;
        tick();
        tick();
        check_offer("sc_offer1", 1'b1, 3'd4);
        irq_i[4]  = 1'b1;
        req_ready = 1'b1;
        tick();                                   // handshake + re-edge
        irq_i = 8'h00;
        check_offer("sc_hs1", 1'b0, 3'd0);
        check("sc_pend_gap", 32'(pend_o), 32'h00);
        tick();
        check("sc_pend_back", 32'(pend_o), 32'h10);
        check_offer("sc_bubble", 1'b0, 3'd0);
        tick();
        check_offer("sc_offer2", 1'b1, 3'd4);
        tick();
        check_offer("sc_hs2", 1'b0, 3'd0);
        tick();
        check("sc_pend_done", 32'(pend_o), 32'h00);
`ifdef IRQ_OVERFLOW_EN
        check("sc_no_ovf", 32'(ovf_o), 32'h00);
`endif

        // 6a Double edge on line 0 before its grant
        req_ready = 1'b0;
        irq_i[0]  = 1'b1;
        tick();
        irq_i = 8'h00;
        tick();
        irq_i[0] = 1'b1;
        tick();
        irq_i = 8'h00;
        check_offer("dbl_offer", 1'b1, 3'd0);
`ifdef IRQ_OVERFLOW_EN
        check("dbl_ovf_set", 32'(ovf_o), 32'h01);
`endif
        req_ready = 1'b1;
        tick();
        check_offer("dbl_hs", 1'b0, 3'd0);
`ifdef IRQ_OVERFLOW_EN
        check("dbl_ovf_clr", 32'(ovf_o), 32'h00);
`endif
        tick();
        tick();
        check("dbl_merged_pend", 32'(pend_o), 32'h00);
        check_offer("dbl_idle", 1'b0, 3'd0);

        // 6b Asynchronous reset during an offer
        req_ready = 1'b0;
        irq_i[1]  = 1'b1;
        tick();
        irq_i = 8'h00;
        irq_i[3] = 1'b1;                         // second line still pending at reset
        tick();
        irq_i = 8'h00;
        tick();
        check_offer("ar_offer", 1'b1, 3'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(req_valid), 32'h0);
        check("ar_idx", 32'(req_idx), 32'h0);
        check("ar_pend", 32'(pend_o), 32'h00);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        check("ar_after_pend", 32'(pend_o), 32'h00);
        check_offer("ar_after", 1'b0, 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
